pll_reset_seq: RTL and testbench
================================

Name: pll_reset_seq

Overview:
- Reset sequencer between the PLL and the SoC. It consumes the PLL's asynchronous lock output and produces the SoC reset.
- Holds the SoC in reset until lock has been stable for a qualification window, then stretches reset for a fixed hold time.
- Re-enters reset on any lock loss or on a soft-reset request.
- Replaces the free-running power-on reset counter at the chip top.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for `locked`; must be >= 2.
- LOCK_CYCLES, 1024: consecutive cycles `locked_s` must stay high before hold begins; must be >= 1.
- HOLD_CYCLES, 128: cycles reset stays asserted after lock qualifies; must be >= 1.
- LOSS_W, 8: width of the saturating lock-loss counter.

Ports:
- clock, input, 1: sole clock, the PLL output domain.
- reset, input, 1: asynchronous, active-high reset of this block.
- locked, input, 1: PLL lock, asynchronous to `clock`.
- soft_req, input, 1: synchronous pulse/level requesting an SoC reset.
- soc_reset, output, 1: registered, active-high reset to the SoC.
- ready, output, 1: registered, high only in RUN.
- state, output, 2: current FSM state (WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3).
- loss_count, output, LOSS_W: number of RUN->WAIT_LOCK lock-loss events, saturating.

Behaviour:
- One clock, `clock`. Reset is asynchronous and active-high on `reset`. All flops are cleared/set asynchronously.
- Values while `reset`=1:
  - sync chain = 0, counter = 0, state = WAIT_LOCK
  - soc_reset = 1, ready = 0, loss_count = 0
- Reset deassertion: the FSM starts from WAIT_LOCK on the first edge after `reset` falls.
- `locked` passes through SYNC_STAGES flops to form `locked_s`. No other logic samples raw `locked`.
- Single down-counter-free up-counter `cnt`, width clog2(max(LOCK_CYCLES, HOLD_CYCLES)), shared by STABLE and HOLD. It is cleared on every state change.
- WAIT_LOCK:
  - soc_reset = 1.
  - `locked_s`=1 -> STABLE with cnt=0.
- STABLE:
  - soc_reset = 1.
  - `locked_s`=0 -> WAIT_LOCK.
  - Otherwise cnt increments; at cnt==LOCK_CYCLES-1 -> HOLD. STABLE therefore lasts exactly LOCK_CYCLES cycles.
- HOLD:
  - soc_reset = 1.
  - `locked_s`=0 -> WAIT_LOCK.
  - At cnt==HOLD_CYCLES-1 -> RUN. HOLD lasts exactly HOLD_CYCLES cycles.
- RUN:
  - soc_reset = 0, ready = 1.
  - `locked_s`=0 -> WAIT_LOCK and loss_count increments, holding at all-ones.
  - Else `soft_req`=1 -> HOLD with cnt=0.
- Priority in any state: lock loss beats soft_req. `soft_req` is ignored outside RUN.
- soc_reset and ready are registered from the next-state value. They change on the same edge the state enters or leaves RUN; there is no extra cycle of lag.
- Release latency: with `locked` held high from before edge 1, soc_reset falls at edge SYNC_STAGES+1+LOCK_CYCLES+HOLD_CYCLES.
- Assert latency on lock loss: soc_reset rises at edge SYNC_STAGES+1 after the first edge sampling `locked`=0.
- Glitch rejection: a `locked` low pulse shorter than one clock period may be missed (acceptable). A pulse seen by the synchronizer restarts qualification fully.
- loss_count counts only losses from RUN. Losses in STABLE or HOLD do not count.

Test Plan (LOCK_CYCLES=16, HOLD_CYCLES=8, SYNC_STAGES=2, LOSS_W=2):
- Power-up:
  - Stimulus: assert `reset`, `locked`=1, release `reset` before edge 1.
  - Required: soc_reset=1 through edge 26, falls at edge 27; ready rises at edge 27; state traces 0->1 at edge 3, 1->2 at edge 19, 2->3 at edge 27.
- Lock flicker during STABLE:
  - Stimulus: drop `locked` for 3 cycles at cycle 10, then restore.
  - Required: state returns to 0; qualification restarts; soc_reset falls 27 edges after restore; loss_count stays 0.
- Lock loss in RUN:
  - Stimulus: drop `locked` in RUN.
  - Required: soc_reset=1 and ready=0 exactly 3 edges later; loss_count=1.
  - Then: repeat the loss 4 times; loss_count saturates at 3.
- Soft reset:
  - Stimulus: 1-cycle `soft_req` in RUN.
  - Required: next edge state=2, soc_reset=1 for exactly 8 cycles, back to RUN; loss_count unchanged.
  - Also: `soft_req` held high during STABLE has no effect.
- Simultaneous events:
  - Stimulus: `soft_req`=1 on the same edge `locked_s` falls in RUN.
  - Required: state->WAIT_LOCK (not HOLD); loss_count increments.
- Async reset mid-HOLD:
  - Stimulus: pulse `reset` between edges.
  - Required: soc_reset=1, state=0, ready=0, loss_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_reset_seq.sv
// Reset sequencer between the PLL and the SoC: qualifies a synchronized PLL lock,
// stretches reset for a hold window, and re-enters reset on lock loss or soft request.
module pll_reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 128,
  parameter int LOSS_W      = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              locked,
  input  logic              soft_req,
  output logic              soc_reset,
  output logic              ready,
  output logic [1:0]        state,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int MAX_CYCLES = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LOSS_W-1:0]      loss_d;
  logic                   soc_reset_d, ready_d;

  // Raw lock is asynchronous; only the last synchronizer stage feeds the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // State register, shared counter, loss counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      loss_count <= '0;
      soc_reset  <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_count <= loss_d;
      soc_reset  <= soc_reset_d;
      ready      <= ready_d;
    end
  end

  // Next state: lock loss always wins over soft_req; cnt clears on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_d  = loss_count;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) state_d = STABLE;
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          if (loss_count != {LOSS_W{1'b1}}) loss_d = loss_count + LOSS_W'(1);
        end else if (soft_req) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they switch on the same edge as RUN entry/exit.
  always_comb begin
    soc_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: directed scenarios plus randomized lock/soft_req
// traffic compared against a streak-length reference model.
module tb_pll_reset_seq;

  localparam int SYNC = 2;
  localparam int LOCK = 16;
  localparam int HOLD = 8;
  localparam int LW   = 2;

  logic          clock    = 1'b0;
  logic          reset    = 1'b1;
  logic          locked   = 1'b0;
  logic          soft_req = 1'b0;
  logic          soc_reset;
  logic          ready;
  logic [1:0]    state;
  logic [LW-1:0] loss_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pll_reset_seq #(
    .SYNC_STAGES(SYNC),
    .LOCK_CYCLES(LOCK),
    .HOLD_CYCLES(HOLD),
    .LOSS_W(LW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .locked(locked),
    .soft_req(soft_req),
    .soc_reset(soc_reset),
    .ready(ready),
    .state(state),
    .loss_count(loss_count)
  );

  // Reference model: m_streak counts consecutive FSM edges that saw lock, and the
  // state follows from where that streak sits relative to the two windows.
  int   m_streak;
  int   m_loss;
  logic m_hist[$];

  function automatic logic [1:0] st_of(int s);
    if (s == 0) return 2'd0;
    if (s <= LOCK) return 2'd1;
    if (s <= LOCK + HOLD) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [LW+3:0] exp_vec();
    logic [1:0] st;
    st = st_of(m_streak);
    return {st, (st != 2'd3), (st == 2'd3), LW'(m_loss)};
  endfunction

  always @(posedge clock or posedge reset) begin : model
    logic ls;
    logic run_now;
    if (reset) begin
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      m_streak <= 0;
      m_loss   <= 0;
    end else begin
      ls = m_hist.pop_front();
      m_hist.push_back(locked);
      run_now = (m_streak > LOCK + HOLD);
      if (!ls) begin
        if (run_now && m_loss < (1 << LW) - 1) m_loss <= m_loss + 1;
        m_streak <= 0;
      end else if (run_now && soft_req) begin
        m_streak <= LOCK + 1;
      end else if (!run_now) begin
        m_streak <= m_streak + 1;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int n;
    n = 0;
    while (st_of(m_streak) != 2'd3 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (st_of(m_streak) != 2'd3) begin
      failures++;
      $display("FAIL wait_run timeout after %0d cycles state=%0d", n, state);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    locked = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (soc_reset !== 1'b1) begin failures++; $display("FAIL reset_soc_reset got=%b exp=1", soc_reset); end
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++;
    if (loss_count !== '0) begin failures++; $display("FAIL reset_loss got=%0d exp=0", loss_count); end
  endtask

  task automatic test_power_up();
    int t_stable, t_hold, t_run, t_fall;
    t_stable = 0; t_hold = 0; t_run = 0; t_fall = 0;
    locked = 1'b1;
    apply_reset();
    for (int e = 1; e <= 32; e++) begin
      @(posedge clock);
      #1;
      checks++;
      if ({state, soc_reset, ready, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL power_up_model edge=%0d got=%b exp=%b", e, {state, soc_reset, ready, loss_count}, exp_vec());
      end
      if (t_stable == 0 && state === 2'd1) t_stable = e;
      if (t_hold == 0 && state === 2'd2) t_hold = e;
      if (t_run == 0 && ready === 1'b1) t_run = e;
      if (t_fall == 0 && soc_reset === 1'b0) t_fall = e;
    end
    checks++;
    if (t_stable != 3) begin failures++; $display("FAIL power_up_stable_edge got=%0d exp=3", t_stable); end
    checks++;
    if (t_hold != 19) begin failures++; $display("FAIL power_up_hold_edge got=%0d exp=19", t_hold); end
    checks++;
    if (t_run != 27) begin failures++; $display("FAIL power_up_ready_edge got=%0d exp=27", t_run); end
    checks++;
    if (t_fall != 27) begin failures++; $display("FAIL power_up_release_edge got=%0d exp=27", t_fall); end
  endtask

  task automatic test_flicker();
    bit saw_wait;
    int t_fall;
    saw_wait = 0;
    t_fall   = 0;
    locked   = 1'b1;
    apply_reset();
    repeat (10) @(posedge clock);
    #1;
    locked = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    locked = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      checks++;
      if ({state, soc_reset, ready, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL flicker_model edge=%0d got=%b exp=%b", e, {state, soc_reset, ready, loss_count}, exp_vec());
      end
      if (state === 2'd0) saw_wait = 1;
      if (t_fall == 0 && soc_reset === 1'b0) t_fall = e;
    end
    checks++;
    if (!saw_wait) begin failures++; $display("FAIL flicker_wait got=0 exp=1"); end
    checks++;
    if (t_fall != 27) begin failures++; $display("FAIL flicker_release_edge got=%0d exp=27", t_fall); end
    checks++;
    if (loss_count !== '0) begin failures++; $display("FAIL flicker_loss got=%0d exp=0", loss_count); end
  endtask

  task automatic test_run_loss();
    locked = 1'b1;
    apply_reset();
    wait_run(60);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      locked = 1'b0;
      for (int e = 1; e <= 3; e++) begin
        @(posedge clock);
        #1;
        checks++;
        if ({state, soc_reset, ready, loss_count} !== exp_vec()) begin
          failures++;
          $display("FAIL run_loss_model loss=%0d edge=%0d got=%b exp=%b", k, e, {state, soc_reset, ready, loss_count}, exp_vec());
        end
        if (k == 0 && e == 2) begin
          checks++;
          if ({soc_reset, ready} !== 2'b01) begin
            failures++;
            $display("FAIL run_loss_early got=%b exp=01", {soc_reset, ready});
          end
        end
      end
      if (k == 0) begin
        checks++;
        if ({soc_reset, ready, loss_count} !== {2'b10, 2'd1}) begin
          failures++;
          $display("FAIL run_loss_edge3 got=%b exp=%b", {soc_reset, ready, loss_count}, {2'b10, 2'd1});
        end
      end
      locked = 1'b1;
      wait_run(60);
    end
    checks++;
    if (loss_count !== 2'd3) begin failures++; $display("FAIL run_loss_saturate got=%0d exp=3", loss_count); end
  endtask

  task automatic test_soft_req();
    int hi, t_fall;
    locked = 1'b1;
    apply_reset();
    wait_run(60);
    @(posedge clock);
    #1;
    soft_req = 1'b1;
    @(posedge clock);
    #1;
    soft_req = 1'b0;
    checks++;
    if ({state, soc_reset} !== 3'b101) begin failures++; $display("FAIL soft_enter_hold got=%b exp=101", {state, soc_reset}); end
    hi = 1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clock);
      #1;
      if (soc_reset !== 1'b1) break;
      hi++;
    end
    checks++;
    if (hi != HOLD) begin failures++; $display("FAIL soft_hold_len got=%0d exp=%0d", hi, HOLD); end
    checks++;
    if ({state, ready, loss_count} !== {2'd3, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL soft_back_run got=%b exp=%b", {state, ready, loss_count}, {2'd3, 1'b1, 2'd0});
    end
    // Lose lock (counts once), then requalify with soft_req held high throughout.
    locked = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    soft_req = 1'b1;
    locked   = 1'b1;
    t_fall   = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clock);
      #1;
      checks++;
      if ({state, soc_reset, ready, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL soft_stable_model edge=%0d got=%b exp=%b", e, {state, soc_reset, ready, loss_count}, exp_vec());
      end
      if (soc_reset === 1'b0) begin
        t_fall = e;
        break;
      end
    end
    soft_req = 1'b0;
    checks++;
    if (t_fall != 27) begin failures++; $display("FAIL soft_ignored_release got=%0d exp=27", t_fall); end
    checks++;
    if (loss_count !== 2'd1) begin failures++; $display("FAIL soft_loss got=%0d exp=1", loss_count); end
  endtask

  task automatic test_simultaneous();
    locked = 1'b1;
    apply_reset();
    wait_run(60);
    @(posedge clock);
    #1;
    locked = 1'b0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    soft_req = 1'b1;
    @(posedge clock);
    #1;
    soft_req = 1'b0;
    checks++;
    if ({state, soc_reset, ready, loss_count} !== {2'd0, 2'b10, 2'd1}) begin
      failures++;
      $display("FAIL simultaneous got=%b exp=%b", {state, soc_reset, ready, loss_count}, {2'd0, 2'b10, 2'd1});
    end
    checks++;
    if ({state, soc_reset, ready, loss_count} !== exp_vec()) begin
      failures++;
      $display("FAIL simultaneous_model got=%b exp=%b", {state, soc_reset, ready, loss_count}, exp_vec());
    end
    locked = 1'b1;
  endtask

  task automatic test_async_reset();
    locked = 1'b1;
    apply_reset();
    wait_run(60);
    @(posedge clock);
    #1;
    locked = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    locked = 1'b1;
    wait_run(60);
    @(posedge clock);
    #1;
    soft_req = 1'b1;
    @(posedge clock);
    #1;
    soft_req = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if ({state, loss_count} !== {2'd2, 2'd1}) begin
      failures++;
      $display("FAIL async_pre got=%b exp=%b", {state, loss_count}, {2'd2, 2'd1});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({state, soc_reset, ready, loss_count} !== {2'd0, 2'b10, 2'd0}) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", {state, soc_reset, ready, loss_count}, {2'd0, 2'b10, 2'd0});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int low_left;
    low_left = 0;
    locked   = 1'b1;
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clock);
      checks++;
      if ({state, soc_reset, ready, loss_count} !== exp_vec()) begin
        failures++;
        $display("FAIL random_model cycle=%0d got=%b exp=%b", i, {state, soc_reset, ready, loss_count}, exp_vec());
      end
      if (low_left > 0) begin
        low_left--;
        if (low_left == 0) locked = 1'b1;
      end else if ($urandom_range(0, 49) == 0) begin
        locked   = 1'b0;
        low_left = $urandom_range(1, 6);
      end
      soft_req = ($urandom_range(0, 29) == 0);
    end
    soft_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_flicker();
    test_run_loss();
    test_soft_req();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
